// File: rtl/operand_fetch_fwd.sv
// Operand-fetch stage: register file, constant bank and carry flag with
// execute/writeback bypass. Detects load-use hazards and holds a one-entry
// registered output under a valid/ready handshake.
module operand_fetch_fwd #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  localparam int IDX_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IDX_W-1:0]  in_src,
  input  logic [IDX_W-1:0]  in_dst,
  input  logic              in_rc,
  input  logic              ex_en,
  input  logic [IDX_W-1:0]  ex_idx,
  input  logic [DATA_W-1:0] ex_data,
  input  logic              ex_pending,
  input  logic              ex_c_en,
  input  logic              ex_c,
  input  logic              wb_en,
  input  logic [IDX_W-1:0]  wb_idx,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              wb_c_en,
  input  logic              wb_c,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] src_val,
  output logic [DATA_W-1:0] dst_val,
  output logic              carry_val
);

  logic [DATA_W-1:0] regs_reg [NUM_REGS];
  logic              carry_reg;

  logic [DATA_W-1:0] const_tbl [NUM_REGS];
  logic [DATA_W-1:0] src_fwd;
  logic [DATA_W-1:0] dst_fwd;
  logic              carry_fwd;
  logic              hazard;
  logic              accept;

  logic              out_valid_reg;
  logic [DATA_W-1:0] src_val_reg;
  logic [DATA_W-1:0] dst_val_reg;
  logic              carry_val_reg;

  // Constant bank: 0, powers of two 1..32, all-ones at 7, zero above 7.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_const
    if (gi == 7) begin : g_ones
      assign const_tbl[gi] = '1;
    end else if (gi >= 1 && gi <= 6) begin : g_pow2
      assign const_tbl[gi] = DATA_W'(1) << (gi - 1);
    end else begin : g_zero
      assign const_tbl[gi] = '0;
    end
  end

  // Source operand: constant bank or bypassed register (ex beats wb beats file).
  always_comb begin
    src_fwd = regs_reg[in_src];
    if (in_rc)
      src_fwd = const_tbl[in_src];
    else if (ex_en && !ex_pending && ex_idx == in_src)
      src_fwd = ex_data;
    else if (wb_en && wb_idx == in_src)
      src_fwd = wb_data;
  end

  // Destination operand: always a bypassed register.
  always_comb begin
    dst_fwd = regs_reg[in_dst];
    if (ex_en && !ex_pending && ex_idx == in_dst)
      dst_fwd = ex_data;
    else if (wb_en && wb_idx == in_dst)
      dst_fwd = wb_data;
  end

  // Carry: execute update, then writeback update, then stored flag.
  always_comb begin
    carry_fwd = carry_reg;
    if (ex_c_en)
      carry_fwd = ex_c;
    else if (wb_c_en)
      carry_fwd = wb_c;
  end

  // A pending load into a register this request reads must stall it; a
  // constant source never depends on the register file.
  assign hazard = in_valid && ex_en && ex_pending &&
                  (ex_idx == in_dst || (!in_rc && ex_idx == in_src));
  assign in_ready = !rst && !hazard && (!out_valid_reg || out_ready);
  assign accept   = in_valid && in_ready;

  // Register file and carry flag write port; writes during reset are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs_reg[i] <= '0;
      carry_reg <= 1'b0;
    end else begin
      if (wb_en)
        regs_reg[wb_idx] <= wb_data;
      if (wb_c_en)
        carry_reg <= wb_c;
    end
  end

  // One-entry output register: load on accept, drain on ready, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      src_val_reg   <= '0;
      dst_val_reg   <= '0;
      carry_val_reg <= 1'b0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      src_val_reg   <= src_fwd;
      dst_val_reg   <= dst_fwd;
      carry_val_reg <= carry_fwd;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign src_val   = src_val_reg;
  assign dst_val   = dst_val_reg;
  assign carry_val = carry_val_reg;

endmodule

// File: tb/tb_operand_fetch_fwd.sv
// Self-checking bench for operand_fetch_fwd: directed scenarios plus a
// randomized run checked against a behavioural model of the stage.
module tb_operand_fetch_fwd;

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready, in_rc;
  logic [2:0]  in_src, in_dst;
  logic        ex_en, ex_pending, ex_c_en, ex_c;
  logic [2:0]  ex_idx;
  logic [15:0] ex_data;
  logic        wb_en, wb_c_en, wb_c;
  logic [2:0]  wb_idx;
  logic [15:0] wb_data;
  logic        out_valid, out_ready, carry_val;
  logic [15:0] src_val, dst_val;

  // Wide instance signals
  logic        w_rst;
  logic        w_in_valid, w_in_ready, w_in_rc;
  logic [3:0]  w_in_src, w_in_dst;
  logic        w_wb_en;
  logic [3:0]  w_wb_idx;
  logic [31:0] w_wb_data;
  logic        w_out_valid, w_carry_val;
  logic [31:0] w_src_val, w_dst_val;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  logic [15:0] m_regs [8];
  logic        m_carry;
  logic        m_ov;
  logic [15:0] m_src, m_dst;
  logic        m_c;

  operand_fetch_fwd dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_src(in_src), .in_dst(in_dst), .in_rc(in_rc),
    .ex_en(ex_en), .ex_idx(ex_idx), .ex_data(ex_data), .ex_pending(ex_pending),
    .ex_c_en(ex_c_en), .ex_c(ex_c),
    .wb_en(wb_en), .wb_idx(wb_idx), .wb_data(wb_data),
    .wb_c_en(wb_c_en), .wb_c(wb_c),
    .out_valid(out_valid), .out_ready(out_ready),
    .src_val(src_val), .dst_val(dst_val), .carry_val(carry_val)
  );

  operand_fetch_fwd #(.DATA_W(32), .NUM_REGS(16)) dut_wide (
    .clk(clk), .rst(w_rst),
    .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_src(w_in_src), .in_dst(w_in_dst), .in_rc(w_in_rc),
    .ex_en(1'b0), .ex_idx(4'd0), .ex_data(32'd0), .ex_pending(1'b0),
    .ex_c_en(1'b0), .ex_c(1'b0),
    .wb_en(w_wb_en), .wb_idx(w_wb_idx), .wb_data(w_wb_data),
    .wb_c_en(1'b0), .wb_c(1'b0),
    .out_valid(w_out_valid), .out_ready(1'b1),
    .src_val(w_src_val), .dst_val(w_dst_val), .carry_val(w_carry_val)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] m_const(input int idx);
    if (idx >= 1 && idx <= 6) return 16'(1 << (idx - 1));
    if (idx == 7) return 16'hFFFF;
    return 16'h0000;
  endfunction

  function automatic logic [15:0] m_read(input logic [2:0] idx);
    if (ex_en && !ex_pending && ex_idx == idx) return ex_data;
    if (wb_en && wb_idx == idx) return wb_data;
    return m_regs[idx];
  endfunction

  function automatic logic m_ready();
    logic hz;
    if (rst) return 1'b0;
    hz = in_valid && ex_en && ex_pending &&
         (ex_idx == in_dst || (!in_rc && ex_idx == in_src));
    return !hz && (!m_ov || out_ready);
  endfunction

  // Advance the model by one clock with the currently driven inputs, then clock the DUT.
  task automatic tick();
    logic acc;
    logic [15:0] s, d;
    logic c;
    acc = in_valid && m_ready();
    s = in_rc ? m_const(int'(in_src)) : m_read(in_src);
    d = m_read(in_dst);
    c = ex_c_en ? ex_c : (wb_c_en ? wb_c : m_carry);
    if (rst) begin
      for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
      m_carry = 1'b0; m_ov = 1'b0; m_src = 16'h0; m_dst = 16'h0; m_c = 1'b0;
    end else begin
      if (acc) begin
        m_ov = 1'b1; m_src = s; m_dst = d; m_c = c;
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
      if (wb_en) m_regs[wb_idx] = wb_data;
      if (wb_c_en) m_carry = wb_c;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 0; in_src = 0; in_dst = 0; in_rc = 0;
    ex_en = 0; ex_idx = 0; ex_data = 0; ex_pending = 0; ex_c_en = 0; ex_c = 0;
    wb_en = 0; wb_idx = 0; wb_data = 0; wb_c_en = 0; wb_c = 0;
    out_ready = 1;
  endtask

  task automatic wb_write(input logic [2:0] idx, input logic [15:0] data);
    idle();
    wb_en = 1; wb_idx = idx; wb_data = data;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst = 1; in_valid = 1; in_src = 3; in_dst = 3;
    #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    tick();
    tick();
    rst = 0;
    idle();
    #1;
    total++;
    if (out_valid !== 1'b0 || src_val !== 16'h0 || dst_val !== 16'h0 || carry_val !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs got v=%b s=%h d=%h c=%b want 0/0000/0000/0",
               out_valid, src_val, dst_val, carry_val);
    end
    $display("txn reset done");
  endtask

  task automatic test_regfile();
    wb_write(3'd3, 16'h1234);
    in_valid = 1; in_src = 3; in_dst = 3; in_rc = 0;
    tick();
    idle();
    total++;
    if (out_valid !== 1'b1 || src_val !== 16'h1234 || dst_val !== 16'h1234) begin
      bad++;
      $display("FAIL regfile_read got v=%b s=%h d=%h want 1/1234/1234", out_valid, src_val, dst_val);
    end
    $display("txn regfile read src=%h dst=%h", src_val, dst_val);
  endtask

  task automatic test_constants();
    logic [15:0] want [3];
    logic [2:0]  idx  [3];
    wb_write(3'd0, 16'h00AA);
    idx[0] = 3'd5; want[0] = 16'h0010;
    idx[1] = 3'd7; want[1] = 16'hFFFF;
    idx[2] = 3'd0; want[2] = 16'h0000;
    for (int k = 0; k < 3; k++) begin
      idle();
      in_valid = 1; in_rc = 1; in_src = idx[k]; in_dst = 0;
      tick();
      total++;
      if (src_val !== want[k] || dst_val !== 16'h00AA) begin
        bad++;
        $display("FAIL const_%0d got s=%h d=%h want s=%h d=00aa", idx[k], src_val, dst_val, want[k]);
      end
      $display("txn const src=%0d src_val=%h dst_val=%h", idx[k], src_val, dst_val);
    end
    idle();
  endtask

  task automatic test_forwarding();
    wb_write(3'd2, 16'h0001);
    in_valid = 1; in_src = 2; in_dst = 2; in_rc = 0;
    wb_en = 1; wb_idx = 2; wb_data = 16'h0002;
    ex_en = 1; ex_idx = 2; ex_data = 16'h0003;
    ex_c_en = 1; ex_c = 1; wb_c_en = 1; wb_c = 0;
    tick();
    idle();
    total++;
    if (src_val !== 16'h0003 || dst_val !== 16'h0003 || carry_val !== 1'b1) begin
      bad++;
      $display("FAIL fwd_ex got s=%h d=%h c=%b want 0003/0003/1", src_val, dst_val, carry_val);
    end
    $display("txn fwd ex src_val=%h", src_val);

    wb_write(3'd2, 16'h0001);
    in_valid = 1; in_src = 2; in_dst = 2; in_rc = 0;
    wb_en = 1; wb_idx = 2; wb_data = 16'h0002;
    wb_c_en = 1; wb_c = 1;
    tick();
    idle();
    total++;
    if (src_val !== 16'h0002 || dst_val !== 16'h0002 || carry_val !== 1'b1) begin
      bad++;
      $display("FAIL fwd_wb got s=%h d=%h c=%b want 0002/0002/1", src_val, dst_val, carry_val);
    end
    $display("txn fwd wb src_val=%h", src_val);

    // No bypass: file now holds 2, carry flag holds 1.
    in_valid = 1; in_src = 2; in_dst = 2;
    tick();
    idle();
    total++;
    if (src_val !== 16'h0002 || carry_val !== 1'b1) begin
      bad++;
      $display("FAIL fwd_file got s=%h c=%b want 0002/1", src_val, carry_val);
    end
    $display("txn file read src_val=%h carry=%b", src_val, carry_val);
  endtask

  task automatic test_load_use();
    idle();
    in_valid = 1; in_rc = 1; in_src = 0; in_dst = 4;
    ex_en = 1; ex_idx = 4; ex_pending = 1; ex_data = 16'hDEAD;
    for (int k = 0; k < 2; k++) begin
      #1;
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL load_use_stall_%0d got=%b want=0", k, in_ready); end
      tick();
    end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL load_use_bubble got=%b want=0", out_valid); end
    ex_pending = 0; ex_data = 16'hBEEF;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL load_use_release got=%b want=1", in_ready); end
    tick();
    idle();
    total++;
    if (out_valid !== 1'b1 || dst_val !== 16'hBEEF) begin
      bad++;
      $display("FAIL load_use_data got v=%b d=%h want 1/beef", out_valid, dst_val);
    end
    $display("txn load-use dst_val=%h", dst_val);
  endtask

  task automatic test_back_pressure();
    wb_write(3'd5, 16'h0505);
    wb_write(3'd6, 16'h0606);
    wb_write(3'd7, 16'h0707);
    tick();
    out_ready = 0;
    in_valid = 1; in_src = 5; in_dst = 5;
    tick();
    total++;
    if (out_valid !== 1'b1 || src_val !== 16'h0505) begin
      bad++;
      $display("FAIL bp_first got v=%b s=%h want 1/0505", out_valid, src_val);
    end
    in_src = 6; in_dst = 6;
    for (int k = 0; k < 2; k++) begin
      #1;
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_%0d got=%b want=0", k, in_ready); end
      tick();
      total++;
      if (out_valid !== 1'b1 || src_val !== 16'h0505 || dst_val !== 16'h0505) begin
        bad++;
        $display("FAIL bp_hold_%0d got v=%b s=%h d=%h want 1/0505/0505", k, out_valid, src_val, dst_val);
      end
    end
    out_ready = 1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%b want=1", in_ready); end
    tick();
    total++;
    if (src_val !== 16'h0606) begin bad++; $display("FAIL bp_second got=%h want=0606", src_val); end
    $display("txn bp second src_val=%h", src_val);
    in_src = 7; in_dst = 7;
    tick();
    total++;
    if (src_val !== 16'h0707) begin bad++; $display("FAIL bp_third got=%h want=0707", src_val); end
    $display("txn bp third src_val=%h", src_val);
    idle();
    tick();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b want=0", out_valid); end
  endtask

  task automatic test_reset_mid();
    wb_write(3'd1, 16'h5555);
    out_ready = 0; in_valid = 1; in_src = 1; in_dst = 1;
    tick();
    total++;
    if (out_valid !== 1'b1 || src_val !== 16'h5555) begin
      bad++;
      $display("FAIL rst_mid_pre got v=%b s=%h want 1/5555", out_valid, src_val);
    end
    rst = 1; out_ready = 1; wb_en = 1; wb_idx = 1; wb_data = 16'h7777;
    #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_mid_ready got=%b want=0", in_ready); end
    tick();
    rst = 0;
    idle();
    #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%b want=0", out_valid); end
    in_valid = 1; in_src = 1; in_dst = 1;
    tick();
    idle();
    total++;
    if (src_val !== 16'h0000 || dst_val !== 16'h0000) begin
      bad++;
      $display("FAIL rst_mid_r1 got s=%h d=%h want 0000/0000", src_val, dst_val);
    end
    $display("txn reset mid-op R1=%h", src_val);
  endtask

  task automatic test_random();
    logic er;
    for (int n = 0; n < 400; n++) begin
      rst        = ($urandom_range(49) == 0);
      in_valid   = $urandom_range(1);
      in_src     = 3'($urandom_range(7));
      in_dst     = 3'($urandom_range(7));
      in_rc      = $urandom_range(1);
      ex_en      = $urandom_range(1);
      ex_idx     = 3'($urandom_range(7));
      ex_data    = 16'($urandom);
      ex_pending = ($urandom_range(2) == 0);
      ex_c_en    = $urandom_range(1);
      ex_c       = $urandom_range(1);
      wb_en      = $urandom_range(1);
      wb_idx     = 3'($urandom_range(7));
      wb_data    = 16'($urandom);
      wb_c_en    = $urandom_range(1);
      wb_c       = $urandom_range(1);
      out_ready  = ($urandom_range(3) != 0);
      #1;
      er = m_ready();
      total++;
      if (in_ready !== er) begin bad++; $display("FAIL rnd_ready n=%0d got=%b want=%b", n, in_ready, er); end
      tick();
      total++;
      if (out_valid !== m_ov || src_val !== m_src || dst_val !== m_dst || carry_val !== m_c) begin
        bad++;
        $display("FAIL rnd_out n=%0d got v=%b s=%h d=%h c=%b want v=%b s=%h d=%h c=%b",
                 n, out_valid, src_val, dst_val, carry_val, m_ov, m_src, m_dst, m_c);
      end
    end
    rst = 0;
    idle();
    $display("txn random run complete");
  endtask

  task automatic test_wide();
    logic [3:0]  idx  [4];
    logic        rc   [4];
    logic [31:0] want [4];
    w_rst = 1; w_in_valid = 0; w_in_src = 0; w_in_dst = 0; w_in_rc = 0;
    w_wb_en = 0; w_wb_idx = 0; w_wb_data = 0;
    @(posedge clk); @(negedge clk);
    w_rst = 0;
    w_wb_en = 1; w_wb_idx = 15; w_wb_data = 32'hDEADBEEF;
    @(posedge clk); @(negedge clk);
    w_wb_en = 0;
    idx[0] = 4'd15; rc[0] = 1; want[0] = 32'h0;
    idx[1] = 4'd15; rc[1] = 0; want[1] = 32'hDEADBEEF;
    idx[2] = 4'd7;  rc[2] = 1; want[2] = 32'hFFFFFFFF;
    idx[3] = 4'd6;  rc[3] = 1; want[3] = 32'h00000020;
    for (int k = 0; k < 4; k++) begin
      w_in_valid = 1; w_in_src = idx[k]; w_in_rc = rc[k]; w_in_dst = 15;
      @(posedge clk); @(negedge clk);
      total++;
      if (w_out_valid !== 1'b1 || w_src_val !== want[k] || w_dst_val !== 32'hDEADBEEF) begin
        bad++;
        $display("FAIL wide_%0d got v=%b s=%h d=%h want 1/%h/deadbeef",
                 k, w_out_valid, w_src_val, w_dst_val, want[k]);
      end
      $display("txn wide src=%0d rc=%b src_val=%h", idx[k], rc[k], w_src_val);
    end
    w_in_valid = 0;
  endtask

  initial begin
    rst = 1;
    idle();
    w_rst = 1; w_in_valid = 0; w_in_src = 0; w_in_dst = 0; w_in_rc = 0;
    w_wb_en = 0; w_wb_idx = 0; w_wb_data = 0;
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
    m_carry = 0; m_ov = 0; m_src = 0; m_dst = 0; m_c = 0;
    @(negedge clk);
    test_reset();
    test_regfile();
    test_constants();
    test_forwarding();
    test_load_use();
    test_back_pressure();
    test_reset_mid();
    test_random();
    test_wide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/operand_fetch_fwd.md
# operand_fetch_fwd

Parametrised operand-fetch stage sitting between decode and the ALU. It owns the general-purpose register file and the constant bank, and resolves source and destination operand values plus carry, with bypass from the execute and writeback stages. Results are presented through a one-entry registered output with a valid/ready handshake. It generalises the earlier combinational register/constant lookup by adding width/depth parameters, a register write port, forwarding, load-use stall detection and pipeline back-pressure.

## Interface
Parameters:
- DATA_W, 16, operand and register width (≥8)
- NUM_REGS, 8, GPRs per bank; power of two, ≥8
- IDX_W, $clog2(NUM_REGS), register index width (derived, not overridden)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  decode presents an operand request
- in_ready  out  1  request accepted this cycle when in_valid && in_ready
- in_src  in  IDX_W  source index
- in_dst  in  IDX_W  destination index
- in_rc  in  1  0 = source from register file, 1 = source from constant bank; dst always from register file
- ex_en  in  1  execute stage will write ex_idx
- ex_idx  in  IDX_W  execute destination
- ex_data  in  DATA_W  execute result
- ex_pending  in  1  execute result not yet available (memory load); ex_data invalid
- ex_c_en, ex_c  in  1,1  execute carry update
- wb_en, wb_idx, wb_data  in  1, IDX_W, DATA_W  register write port
- wb_c_en, wb_c  in  1,1  carry write port
- out_valid  out  1  operands valid
- out_ready  in  1  ALU consumes operands
- src_val, dst_val  out  DATA_W  resolved operands
- carry_val  out  1  resolved carry

## Operation
- Register file: NUM_REGS × DATA_W, plus one carry flag. Written at the clock edge when wb_en / wb_c_en.
- Constant bank, indexed by in_src:
  - 0 → 0
  - 1..6 → 1 << (idx−1), i.e. 1, 2, 4, 8, 16, 32
  - 7 → all ones (−1)
  - ≥8 → 0
  - Zero-extended to DATA_W, except −1.
- Register operand resolution, in priority order:
  - ex_en && ex_idx == idx && !ex_pending → ex_data
  - else wb_en && wb_idx == idx → wb_data
  - else register file contents
- Constants are never forwarded.
- Carry resolution: ex_c_en → ex_c; else wb_c_en → wb_c; else stored flag.
- Stall: hazard = in_valid && ex_en && ex_pending && (ex_idx == in_dst || (!in_rc && ex_idx == in_src)).
- in_ready = !hazard && (!out_valid || out_ready).
- Output register:
  - On accept, src_val/dst_val/carry_val are loaded with the resolved values and out_valid is set to 1.
  - Else if out_ready, out_valid is cleared to 0.
  - Else all outputs hold.
- Held outputs are not refreshed by later ex/wb updates. Decode must not advance past a held instruction that depends on a later write; the pipeline ordering guarantees this.
- Simultaneous wb write and read of the same index: the read returns wb_data (write-through), and the file is also updated.
- Simultaneous ex and wb to the same index: ex wins for the read; wb still updates the file.

## Timing
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 request/cycle when out_ready is held high and there is no hazard.
- in_ready is combinational from in_*, ex_*, out_valid and out_ready. No combinational path exists from in_valid to out_valid.
- Hazard stall lasts while ex_pending is high. On the cycle ex_pending drops, with ex_en still set, the request is accepted with ex_data forwarded.
- Reset values, asserted the cycle after rst:
  - out_valid = 0; src_val = dst_val = 0; carry_val = 0
  - all GPRs = 0; carry flag = 0
- in_ready is 0 during the rst cycle.
- Reset mid-operation discards the held output and any in-flight request. Writes presented during rst are ignored.

## Test plan
- Reset, then wb writes R3 = 0x1234; next cycle request src = 3, dst = 3, rc = 0 → one cycle later out_valid = 1, src_val = dst_val = 0x1234.
- Request rc = 1, src = 5, dst = 0, with R0 = 0x00AA → src_val = 0x0010, dst_val = 0x00AA. Same with src = 7 → src_val = 0xFFFF.
- Forwarding: R2 = 0x0001 in file, wb_en on R2 = 0x0002 and ex_en on R2 = 0x0003 in the same cycle as a request for src = 2 → src_val = 0x0003. Without ex_en → 0x0002.
- Load-use: ex_en, ex_pending, ex_idx = 4 for 2 cycles, request dst = 4 → in_ready = 0 for 2 cycles. On the third cycle, with ex_pending = 0 and ex_data = 0xBEEF, the request is accepted and dst_val = 0xBEEF.
- Back-pressure: out_ready = 0 with 3 back-to-back requests → first held, in_ready = 0, outputs stable. Raise out_ready → remaining requests accepted one per cycle, in order.
- Assert rst for 1 cycle while out_valid = 1 and R1 = 0x5555 → out_valid = 0, and a later read of R1 returns 0. Repeat with DATA_W = 32, NUM_REGS = 16: src = 15 with rc = 1 → 0.
